// File: rtl/register_writer.sv
// register_writer
//   Write-back half of the register datapath. Holds the architectural
//   registers and updates them from the result bus on the even write
//   phases (clock_4, clock_6, clock_8). Also does esp push/pop arithmetic
//   and advances eip at the end of each instruction.
//
// Ports
//   clock, reset          system clock, async active-high reset
//   clock_4/6/8           one-cycle write phase strobes
//   select_1/2/3          4-bit write-select code for each phase
//   write_data            result bus value
//   instr_len             byte length of the current instruction
//   stall                 freezes all state and discards the cycle's strobes
//   eip..ebx              registered architectural registers
//   phase_error           sticky, set when two or more strobes coincide
module register_writer #(
  parameter logic [31:0] RESET_SP = 32'h0000_0100,
  parameter int unsigned WORD     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_4,
  input  logic        clock_6,
  input  logic        clock_8,
  input  logic [3:0]  select_1,
  input  logic [3:0]  select_2,
  input  logic [3:0]  select_3,
  input  logic [31:0] write_data,
  input  logic [3:0]  instr_len,
  input  logic        stall,
  output logic [31:0] eip,
  output logic [31:0] ebp,
  output logic [31:0] esp,
  output logic [31:0] eax,
  output logic [31:0] edi,
  output logic [31:0] ebx,
  output logic        phase_error
);

  localparam logic [31:0] WORD_W = 32'(WORD);

  localparam logic [3:0] CODE_PUSH = 4'h1;
  localparam logic [3:0] CODE_ESP  = 4'h2;
  localparam logic [3:0] CODE_POP  = 4'h3;
  localparam logic [3:0] CODE_EBP  = 4'h5;
  localparam logic [3:0] CODE_EAX  = 4'h6;
  localparam logic [3:0] CODE_EIP  = 4'h7;
  localparam logic [3:0] CODE_EDI  = 4'h8;
  localparam logic [3:0] CODE_EBX  = 4'h9;

  logic [31:0] eip_q, eip_d;
  logic [31:0] ebp_q, ebp_d;
  logic [31:0] esp_q, esp_d;
  logic [31:0] eax_q, eax_d;
  logic [31:0] edi_q, edi_d;
  logic [31:0] ebx_q, ebx_d;
  logic        eip_written_q, eip_written_d;
  logic        phase_error_q, phase_error_d;

  logic        any_strobe;
  logic        multi_strobe;
  logic        commit;
  logic [3:0]  code;

  assign any_strobe   = clock_4 | clock_6 | clock_8;
  assign multi_strobe = (clock_4 & clock_6) | (clock_4 & clock_8) | (clock_6 & clock_8);
  assign commit       = any_strobe & ~stall;
  // Later phase wins when strobes collide.
  assign code         = clock_8 ? select_3 : (clock_6 ? select_2 : select_1);

  always_comb begin
    eip_d         = eip_q;
    ebp_d         = ebp_q;
    esp_d         = esp_q;
    eax_d         = eax_q;
    edi_d         = edi_q;
    ebx_d         = ebx_q;
    eip_written_d = eip_written_q;
    phase_error_d = phase_error_q;

    if (commit) begin
      if (multi_strobe) phase_error_d = 1'b1;

      case (code)
        CODE_PUSH: esp_d = esp_q - WORD_W;
        CODE_ESP:  esp_d = write_data;
        CODE_POP:  esp_d = esp_q + WORD_W;
        CODE_EBP:  ebp_d = write_data;
        CODE_EAX:  eax_d = write_data;
        CODE_EIP:  eip_d = write_data;
        CODE_EDI:  edi_d = write_data;
        CODE_EBX:  ebx_d = write_data;
        default:   ;
      endcase

      if (clock_8) begin
        // End of instruction: fall through to the next one unless a jump
        // already landed in this instruction (earlier phase or this one).
        eip_written_d = 1'b0;
        if (code != CODE_EIP && !eip_written_q)
          eip_d = eip_q + {28'b0, instr_len};
      end else if (code == CODE_EIP) begin
        eip_written_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eip_q         <= '0;
      ebp_q         <= RESET_SP;
      esp_q         <= RESET_SP;
      eax_q         <= '0;
      edi_q         <= '0;
      ebx_q         <= '0;
      eip_written_q <= 1'b0;
      phase_error_q <= 1'b0;
    end else begin
      eip_q         <= eip_d;
      ebp_q         <= ebp_d;
      esp_q         <= esp_d;
      eax_q         <= eax_d;
      edi_q         <= edi_d;
      ebx_q         <= ebx_d;
      eip_written_q <= eip_written_d;
      phase_error_q <= phase_error_d;
    end
  end

  assign eip         = eip_q;
  assign ebp         = ebp_q;
  assign esp         = esp_q;
  assign eax         = eax_q;
  assign edi         = edi_q;
  assign ebx         = ebx_q;
  assign phase_error = phase_error_q;

endmodule

// File: tb/tb_register_writer.sv
module tb_register_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        clock_4, clock_6, clock_8;
  logic [3:0]  select_1, select_2, select_3;
  logic [31:0] write_data;
  logic [3:0]  instr_len;
  logic        stall;
  logic [31:0] eip, ebp, esp, eax, edi, ebx;
  logic        phase_error;

  int checks = 0;
  int errors = 0;

  register_writer #(.RESET_SP(32'h0000_0100), .WORD(4)) dut (
    .clock(clock), .reset(reset),
    .clock_4(clock_4), .clock_6(clock_6), .clock_8(clock_8),
    .select_1(select_1), .select_2(select_2), .select_3(select_3),
    .write_data(write_data), .instr_len(instr_len), .stall(stall),
    .eip(eip), .ebp(ebp), .esp(esp), .eax(eax), .edi(edi), .ebx(ebx),
    .phase_error(phase_error)
  );

  always #5 clock = ~clock;

  // One clock with the given strobes (bit2=clock_8, bit1=clock_6, bit0=clock_4)
  // and the same select on every phase; returns #1 after the rising edge.
  task automatic cyc(input logic [2:0] strobes, input logic [3:0] sel,
                     input logic [31:0] data, input logic [3:0] len);
    @(negedge clock);
    clock_4 = strobes[0]; clock_6 = strobes[1]; clock_8 = strobes[2];
    select_1 = sel; select_2 = sel; select_3 = sel;
    write_data = data; instr_len = len;
    @(posedge clock); #1;
    clock_4 = 1'b0; clock_6 = 1'b0; clock_8 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clock_4 = 1'b1; select_1 = 4'h6; write_data = 32'hFFFF_FFFF;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (eip !== 32'h0) begin errors++; $display("FAIL reset_eip got %h want %h", eip, 32'h0); end
    checks++; if (esp !== 32'h100) begin errors++; $display("FAIL reset_esp got %h want %h", esp, 32'h100); end
    checks++; if (ebp !== 32'h100) begin errors++; $display("FAIL reset_ebp got %h want %h", ebp, 32'h100); end
    checks++; if ({eax, edi, ebx} !== 96'h0) begin errors++; $display("FAIL reset_gprs got %h want 0", {eax, edi, ebx}); end
    checks++; if (phase_error !== 1'b0) begin errors++; $display("FAIL reset_phase_error got %b want 0", phase_error); end
    @(negedge clock);
    clock_4 = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_push_pop;
    cyc(3'b001, 4'h1, 32'h0, 4'h0);
    checks++; if (esp !== 32'h0000_00FC) begin errors++; $display("FAIL push1_esp got %h want %h", esp, 32'h0000_00FC); end
    cyc(3'b010, 4'h1, 32'h0, 4'h0);
    checks++; if (esp !== 32'h0000_00F8) begin errors++; $display("FAIL push2_esp got %h want %h", esp, 32'h0000_00F8); end
    cyc(3'b100, 4'h3, 32'h0, 4'h2);
    checks++; if (esp !== 32'h0000_00FC) begin errors++; $display("FAIL pop_esp got %h want %h", esp, 32'h0000_00FC); end
    checks++; if (eip !== 32'h2) begin errors++; $display("FAIL pop_eip_adv got %h want %h", eip, 32'h2); end
  endtask

  task automatic test_data_writes;
    // Set eip to 0x10 via a jump, ending that instruction with no advance.
    cyc(3'b001, 4'h7, 32'h10, 4'h0);
    cyc(3'b100, 4'h0, 32'h0, 4'h9);
    checks++; if (eip !== 32'h10) begin errors++; $display("FAIL jump_setup_eip got %h want %h", eip, 32'h10); end
    cyc(3'b001, 4'h6, 32'h1234_5678, 4'h0);
    checks++; if (eax !== 32'h1234_5678) begin errors++; $display("FAIL eax_write got %h want %h", eax, 32'h1234_5678); end
    cyc(3'b010, 4'h9, 32'h0000_00AA, 4'h0);
    checks++; if (ebx !== 32'h0000_00AA) begin errors++; $display("FAIL ebx_write got %h want %h", ebx, 32'h0000_00AA); end
    cyc(3'b100, 4'h8, 32'hCAFE_0001, 4'h3);
    checks++; if (edi !== 32'hCAFE_0001) begin errors++; $display("FAIL edi_write got %h want %h", edi, 32'hCAFE_0001); end
    checks++; if (eip !== 32'h13) begin errors++; $display("FAIL eip_advance got %h want %h", eip, 32'h13); end
    // ebp via a back-to-back strobe on the very next cycle.
    cyc(3'b001, 4'h5, 32'h0000_0200, 4'h0);
    cyc(3'b010, 4'h5, 32'h0000_0300, 4'h0);
    checks++; if (ebp !== 32'h0000_0300) begin errors++; $display("FAIL ebp_b2b got %h want %h", ebp, 32'h0000_0300); end
    cyc(3'b100, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic test_jump;
    cyc(3'b010, 4'h7, 32'h0000_0400, 4'h0);
    checks++; if (eip !== 32'h0000_0400) begin errors++; $display("FAIL jump_eip got %h want %h", eip, 32'h0000_0400); end
    cyc(3'b100, 4'h0, 32'h0, 4'h5);
    checks++; if (eip !== 32'h0000_0400) begin errors++; $display("FAIL jump_no_adv got %h want %h", eip, 32'h0000_0400); end
    cyc(3'b100, 4'h0, 32'h0, 4'h5);
    checks++; if (eip !== 32'h0000_0405) begin errors++; $display("FAIL next_adv got %h want %h", eip, 32'h0000_0405); end
    // A code-7 on clock_8 itself loads write_data, not the advance.
    cyc(3'b100, 4'h7, 32'h0000_0500, 4'hF);
    checks++; if (eip !== 32'h0000_0500) begin errors++; $display("FAIL jump_c8 got %h want %h", eip, 32'h0000_0500); end
    cyc(3'b100, 4'h0, 32'h0, 4'h5);
    checks++; if (eip !== 32'h0000_0505) begin errors++; $display("FAIL jump_c8_next got %h want %h", eip, 32'h0000_0505); end
  endtask

  task automatic test_wrap_stall_ignored;
    cyc(3'b001, 4'h2, 32'h0, 4'h0);
    checks++; if (esp !== 32'h0) begin errors++; $display("FAIL esp_load0 got %h want %h", esp, 32'h0); end
    cyc(3'b010, 4'h1, 32'h0, 4'h0);
    checks++; if (esp !== 32'hFFFF_FFFC) begin errors++; $display("FAIL push_wrap got %h want %h", esp, 32'hFFFF_FFFC); end
    cyc(3'b100, 4'h3, 32'h0, 4'h0);
    checks++; if (esp !== 32'h0) begin errors++; $display("FAIL pop_wrap got %h want %h", esp, 32'h0); end
    stall = 1'b1;
    cyc(3'b001, 4'h6, 32'hDEAD_BEEF, 4'h0);
    checks++; if (eax !== 32'h1234_5678) begin errors++; $display("FAIL stall_eax got %h want %h", eax, 32'h1234_5678); end
    cyc(3'b100, 4'h0, 32'h0, 4'h1);
    checks++; if (eip !== 32'h0000_0505) begin errors++; $display("FAIL stall_eip got %h want %h", eip, 32'h0000_0505); end
    cyc(3'b011, 4'h6, 32'hDEAD_BEEF, 4'h0);
    checks++; if (phase_error !== 1'b0) begin errors++; $display("FAIL stall_collision_pe got %b want 0", phase_error); end
    stall = 1'b0;
    // Stalled strobes are discarded: a following idle cycle writes nothing.
    cyc(3'b000, 4'h6, 32'hDEAD_BEEF, 4'h0);
    checks++; if (eax !== 32'h1234_5678) begin errors++; $display("FAIL no_strobe_eax got %h want %h", eax, 32'h1234_5678); end
    cyc(3'b001, 4'h4, 32'h0000_0055, 4'h0);
    cyc(3'b010, 4'hA, 32'h0000_0055, 4'h0);
    checks++; if ({esp, ebp, eax, edi, ebx, eip} !== {32'h0, 32'h300, 32'h1234_5678, 32'hCAFE_0001, 32'hAA, 32'h505})
      begin errors++; $display("FAIL ignored_codes got %h want %h", {esp, ebp, eax, edi, ebx, eip}, {32'h0, 32'h300, 32'h1234_5678, 32'hCAFE_0001, 32'hAA, 32'h505}); end
  endtask

  task automatic test_collision;
    @(negedge clock);
    clock_4 = 1'b1; clock_8 = 1'b1; clock_6 = 1'b0;
    select_1 = 4'h6; select_2 = 4'h0; select_3 = 4'h5;
    write_data = 32'h1; instr_len = 4'h0;
    @(posedge clock); #1;
    clock_4 = 1'b0; clock_8 = 1'b0;
    checks++; if (ebp !== 32'h1) begin errors++; $display("FAIL coll_ebp got %h want %h", ebp, 32'h1); end
    checks++; if (eax !== 32'h1234_5678) begin errors++; $display("FAIL coll_eax got %h want %h", eax, 32'h1234_5678); end
    checks++; if (phase_error !== 1'b1) begin errors++; $display("FAIL coll_pe got %b want 1", phase_error); end
    cyc(3'b001, 4'h6, 32'h7, 4'h0);
    cyc(3'b010, 4'h0, 32'h0, 4'h0);
    checks++; if (eax !== 32'h7) begin errors++; $display("FAIL post_coll_eax got %h want %h", eax, 32'h7); end
    checks++; if (phase_error !== 1'b1) begin errors++; $display("FAIL pe_sticky got %b want 1", phase_error); end
  endtask

  task automatic test_async_reset;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if ({eip, eax, edi, ebx} !== 128'h0) begin errors++; $display("FAIL async_clear got %h want 0", {eip, eax, edi, ebx}); end
    checks++; if ({esp, ebp} !== {32'h100, 32'h100}) begin errors++; $display("FAIL async_sp got %h want %h", {esp, ebp}, {32'h100, 32'h100}); end
    checks++; if (phase_error !== 1'b0) begin errors++; $display("FAIL async_pe got %b want 0", phase_error); end
    cyc(3'b001, 4'h6, 32'h99, 4'h0);
    checks++; if (eax !== 32'h0) begin errors++; $display("FAIL reset_hold got %h want %h", eax, 32'h0); end
    @(negedge clock);
    reset = 1'b0;
    cyc(3'b001, 4'h6, 32'h99, 4'h0);
    checks++; if (eax !== 32'h99) begin errors++; $display("FAIL first_after_reset got %h want %h", eax, 32'h99); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    clock_4 = 1'b0; clock_6 = 1'b0; clock_8 = 1'b0;
    select_1 = 4'h0; select_2 = 4'h0; select_3 = 4'h0;
    write_data = 32'h0; instr_len = 4'h0;
    test_reset;
    test_push_pop;
    test_data_writes;
    test_jump;
    test_wrap_stall_ignored;
    test_collision;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
